// File: rtl/serdes_rx_framer.sv
// serdes_rx_framer: hunts a serial lane for a comma, qualifies alignment, emits aligned parallel words
module serdes_rx_framer #(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD     = 8'hBC,
    parameter int                    LOCK_COUNT    = 3,
    parameter int                    SYNC_INTERVAL = 16
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  sdata_in,
    input  logic                  sdata_valid,
    output logic [DATA_WIDTH-1:0] pdata_out,
    output logic                  pdata_valid,
    output logic                  locked,
    output logic                  align_err
);
    localparam int BW  = $clog2(DATA_WIDTH);
    localparam int GW  = $clog2(LOCK_COUNT + 1);
    localparam int GPW = $clog2(SYNC_INTERVAL + 1);
    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] win_q, win_d, pdata_q, pdata_d, nxt_win;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]         good_cnt_q, good_cnt_d;
    logic [GPW-1:0]        gap_cnt_q, gap_cnt_d;
    logic                  pvalid_q, pvalid_d, locked_q, locked_d, aerr_q, aerr_d;
    logic                  boundary, is_sync;

    // Next-state: shift in one LSB-first bit per valid cycle and advance the alignment FSM
    always_comb begin
        nxt_win    = {sdata_in, win_q[DATA_WIDTH-1:1]};
        boundary   = bit_cnt_q == BW'(DATA_WIDTH - 1);
        is_sync    = nxt_win == SYNC_WORD;
        state_d    = state_q;
        win_d      = win_q;
        bit_cnt_d  = bit_cnt_q;
        good_cnt_d = good_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pdata_d    = pdata_q;
        locked_d   = locked_q;
        pvalid_d   = 1'b0;
        aerr_d     = 1'b0;
        if (sdata_valid) begin
            win_d     = nxt_win;
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
            case (state_q)
                HUNT: begin
                    if (is_sync) begin
                        bit_cnt_d  = '0;
                        good_cnt_d = GW'(1);
                        if (LOCK_COUNT == 1) begin
                            state_d   = LOCKED;
                            locked_d  = 1'b1;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (boundary && is_sync) begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                            state_d   = LOCKED;
                            locked_d  = 1'b1;
                            gap_cnt_d = '0;
                        end
                    end else if (boundary) begin
                        state_d    = HUNT;
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (boundary && is_sync) begin
                        gap_cnt_d = '0;
                    end else if (boundary && gap_cnt_q < GPW'(SYNC_INTERVAL)) begin
                        pdata_d   = nxt_win;
                        pvalid_d  = 1'b1;
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end else if (boundary) begin
                        aerr_d     = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = HUNT;
                        bit_cnt_d  = '0;
                        good_cnt_d = '0;
                        gap_cnt_d  = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State and output registers, cleared immediately on reset even mid-word
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            win_q      <= '0;
            bit_cnt_q  <= '0;
            good_cnt_q <= '0;
            gap_cnt_q  <= '0;
            pdata_q    <= '0;
            pvalid_q   <= 1'b0;
            locked_q   <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            bit_cnt_q  <= bit_cnt_d;
            good_cnt_q <= good_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pdata_q    <= pdata_d;
            pvalid_q   <= pvalid_d;
            locked_q   <= locked_d;
            aerr_q     <= aerr_d;
        end
    end

    assign pdata_out   = pdata_q;
    assign pdata_valid = pvalid_q;
    assign locked      = locked_q;
    assign align_err   = aerr_q;
endmodule

// File: tb/tb_serdes_rx_framer.sv
// tb_serdes_rx_framer: scoreboard bench for the serial framer
module tb_serdes_rx_framer;
    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sdata_in = 1'b0;
    logic       sdata_valid = 1'b0;
    logic [7:0] pdata_out;
    logic       pdata_valid;
    logic       locked;
    logic       align_err;
    logic [7:0] exp_q[$];
    int nchecks = 0;
    int nfail = 0;
    int npulse = 0;
    int naerr = 0;

    serdes_rx_framer dut (
        .sclk(sclk),
        .rst_n(rst_n),
        .sdata_in(sdata_in),
        .sdata_valid(sdata_valid),
        .pdata_out(pdata_out),
        .pdata_valid(pdata_valid),
        .locked(locked),
        .align_err(align_err)
    );

    always #5 sclk = ~sclk;

    initial begin
        #400000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Drive one bit, clock it, and score any word the DUT emits on that edge
    task automatic send_bit(input logic b, input logic v);
        logic [7:0] e;
        sdata_in = b;
        sdata_valid = v;
        @(posedge sclk);
        #1;
        if (align_err === 1'b1) naerr++;
        if (pdata_valid === 1'b1) begin
            npulse++;
            nchecks++;
            if (!v) begin
                nfail++;
                $display("FAIL stall_pulse pdata_valid got 1 after stalled cycle, want 0");
            end
            nchecks++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_word got %02h, want no output", pdata_out);
            end else begin
                e = exp_q.pop_front();
                if (pdata_out !== e) begin
                    nfail++;
                    $display("FAIL data_word got %02h, want %02h", pdata_out, e);
                end
            end
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int stall_pct);
        for (int i = 0; i < 8; i++) begin
            while ($urandom_range(99) < stall_pct) send_bit(1'($urandom), 1'b0);
            send_bit(w[i], 1'b1);
        end
    endtask

    task automatic do_reset();
        sdata_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_locked(input logic want, input string name);
        nchecks++;
        if (locked !== want) begin
            nfail++;
            $display("FAIL %s locked got %b, want %b", name, locked, want);
        end
    endtask

    task automatic check_q_empty(input string name);
        nchecks++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL %s missing words got %0d pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic acquire(input int stall_pct, input string name);
        for (int k = 0; k < 3; k++) begin
            send_word(8'hBC, stall_pct);
            check_locked(k == 2, name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1'($urandom));
        nchecks++;
        if ({pdata_out, pdata_valid, locked, align_err} !== 11'd0) begin
            nfail++;
            $display("FAIL reset_outputs got %03h, want 000", {pdata_out, pdata_valid, locked, align_err});
        end
        check_q_empty("reset_no_words");
        rst_n = 1'b1;
    endtask

    task automatic test_acquire();
        int p0;
        do_reset();
        p0 = npulse;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        check_locked(1'b0, "acq_prefix");
        acquire(0, "acq");
        nchecks++;
        if (npulse != p0) begin
            nfail++;
            $display("FAIL acq_no_pulse got %0d pulses, want 0", npulse - p0);
        end
    endtask

    task automatic test_data(input int stall_pct, input string name);
        logic [7:0] words[4] = '{8'h5A, 8'h3C, 8'hBC, 8'hA5};
        int p0;
        p0 = npulse;
        for (int i = 0; i < 4; i++) begin
            if (words[i] != 8'hBC) exp_q.push_back(words[i]);
            send_word(words[i], stall_pct);
            nchecks++;
            if (pdata_valid !== (words[i] != 8'hBC)) begin
                nfail++;
                $display("FAIL %s_latency word %0d pdata_valid got %b, want %b", name, i, pdata_valid, words[i] != 8'hBC);
            end
        end
        send_bit(1'b0, 1'b0);
        check_q_empty(name);
        nchecks++;
        if (npulse - p0 != 3) begin
            nfail++;
            $display("FAIL %s_pulses got %0d, want 3", name, npulse - p0);
        end
    endtask

    task automatic test_verify_fail();
        int a0;
        do_reset();
        a0 = naerr;
        send_word(8'hBC, 0);
        send_word(8'hBC, 0);
        send_word(8'h00, 0);
        check_locked(1'b0, "vfail_unlocked");
        nchecks++;
        if (naerr != a0) begin
            nfail++;
            $display("FAIL vfail_no_err got %0d align_err pulses, want 0", naerr - a0);
        end
        acquire(0, "vfail_relock");
    endtask

    task automatic test_lock_loss();
        int a0;
        int p0;
        do_reset();
        acquire(0, "loss_lock");
        a0 = naerr;
        p0 = npulse;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'h11);
            send_word(8'h11, 0);
        end
        nchecks++;
        if (align_err !== 1'b1 || pdata_valid !== 1'b0) begin
            nfail++;
            $display("FAIL loss_17th align_err/pdata_valid got %b/%b, want 1/0", align_err, pdata_valid);
        end
        check_locked(1'b0, "loss_unlocked");
        send_bit(1'b0, 1'b1);
        nchecks++;
        if (align_err !== 1'b0) begin
            nfail++;
            $display("FAIL loss_err_pulse align_err got %b one cycle later, want 0", align_err);
        end
        check_q_empty("loss_words");
        nchecks++;
        if (naerr - a0 != 1 || npulse - p0 != 16) begin
            nfail++;
            $display("FAIL loss_counts got err=%0d pulses=%0d, want err=1 pulses=16", naerr - a0, npulse - p0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        acquire(0, "mid_lock");
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_locked(1'b0, "mid_async_drop");
        @(negedge sclk);
        rst_n = 1'b1;
        @(posedge sclk);
        #1;
        acquire(0, "mid_relock");
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_data(0, "data");
        test_verify_fail();
        test_lock_loss();
        do_reset();
        acquire(40, "stall_lock");
        test_data(40, "stall");
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
